// File: rtl/rob_ctrl.sv
// 8-entry in-order reorder buffer: issue allocates at tail, CDB marks results ready, one in-order commit per cycle.
// Commit is a registered pulse one edge after the head becomes ready; issue stalls while full (iss_ready=0).
module rob_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [3:0]        iss_dest,
  output logic              iss_ready,
  output logic [2:0]        iss_tag,
  input  logic              cdb_valid,
  input  logic [2:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              cmt_valid,
  output logic [3:0]        cmt_dest,
  output logic [2:0]        cmt_tag,
  output logic [DATA_W-1:0] cmt_value,
  input  logic              flush,
  input  logic [3:0]        qry_reg,
  output logic              qry_hit,
  output logic [2:0]        qry_tag,
  output logic              qry_ready,
  output logic [DATA_W-1:0] qry_value,
  output logic [3:0]        count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             rdy;
  logic [DEPTH-1:0][3:0]        dest;
  logic [DEPTH-1:0][DATA_W-1:0] val;
  logic [2:0]                   head_p;
  logic [2:0]                   tail_p;
  logic [2:0]                   qidx;

  logic do_iss;
  logic do_cmt;
  logic do_cdb;

  assign empty     = (count == 4'd0);
  assign full      = (count == 4'(DEPTH));
  assign iss_ready = ~full;
  assign iss_tag   = tail_p;

  // All three decisions look only at pre-edge state, so a same-cycle issue
  // never receives a broadcast and a fresh result never commits without a cycle gap.
  assign do_iss = iss_valid & ~full;
  assign do_cmt = busy[head_p] & rdy[head_p];
  assign do_cdb = cdb_valid & busy[cdb_tag] & ~rdy[cdb_tag];

  // Walk from oldest to youngest; the last match seen is the youngest writer.
  always_comb begin
    qry_hit   = 1'b0;
    qry_tag   = 3'd0;
    qry_ready = 1'b0;
    qry_value = '0;
    qidx      = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      qidx = head_p + 3'(k);
      if (busy[qidx] && (dest[qidx] == qry_reg)) begin
        qry_hit   = 1'b1;
        qry_tag   = qidx;
        qry_ready = rdy[qidx];
        qry_value = val[qidx];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      busy      <= '0;
      rdy       <= '0;
      dest      <= '0;
      val       <= '0;
      head_p    <= 3'd0;
      tail_p    <= 3'd0;
      count     <= 4'd0;
      cmt_valid <= 1'b0;
      cmt_dest  <= 4'd0;
      cmt_tag   <= 3'd0;
      cmt_value <= '0;
    end else if (flush) begin
      busy      <= '0;
      rdy       <= '0;
      head_p    <= 3'd0;
      tail_p    <= 3'd0;
      count     <= 4'd0;
      cmt_valid <= 1'b0;
    end else begin
      cmt_valid <= do_cmt;
      if (do_cmt) begin
        cmt_dest     <= dest[head_p];
        cmt_tag      <= head_p;
        cmt_value    <= val[head_p];
        busy[head_p] <= 1'b0;
        head_p       <= head_p + 3'd1;
      end
      if (do_iss) begin
        busy[tail_p] <= 1'b1;
        rdy[tail_p]  <= 1'b0;
        dest[tail_p] <= iss_dest;
        tail_p       <= tail_p + 3'd1;
      end
      if (do_cdb) begin
        rdy[cdb_tag] <= 1'b1;
        val[cdb_tag] <= cdb_value;
      end
      case ({do_iss, do_cmt})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl: issue/CDB/commit ordering, full stall, rename query, flush and reset.
module tb_rob_ctrl;
  localparam int DATA_W = 16;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              iss_valid;
  logic [3:0]        iss_dest;
  logic              iss_ready;
  logic [2:0]        iss_tag;
  logic              cdb_valid;
  logic [2:0]        cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cmt_valid;
  logic [3:0]        cmt_dest;
  logic [2:0]        cmt_tag;
  logic [DATA_W-1:0] cmt_value;
  logic              flush;
  logic [3:0]        qry_reg;
  logic              qry_hit;
  logic [2:0]        qry_tag;
  logic              qry_ready;
  logic [DATA_W-1:0] qry_value;
  logic [3:0]        count;
  logic              empty;
  logic              full;

  int checks = 0;
  int errors = 0;

  rob_ctrl #(.DATA_W(DATA_W), .DEPTH(8)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cmt_valid(cmt_valid), .cmt_dest(cmt_dest), .cmt_tag(cmt_tag), .cmt_value(cmt_value),
    .flush(flush), .qry_reg(qry_reg),
    .qry_hit(qry_hit), .qry_tag(qry_tag), .qry_ready(qry_ready), .qry_value(qry_value),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic issue(input logic [3:0] d);
    iss_valid = 1'b1;
    iss_dest  = d;
    tick();
    iss_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [DATA_W-1:0] v);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_value = v;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_dest = 4'd0; cdb_valid = 1'b0;
    cdb_tag = 3'd0; cdb_value = '0; flush = 1'b0; qry_reg = 4'd0;
    tick();
    tick();
    rst_n = 1'b1;

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_iss_ready", 32'(iss_ready), 32'd1);
    chk("rst_iss_tag", 32'(iss_tag), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_cmt_valid", 32'(cmt_valid), 32'd0);
    chk("rst_qry_hit", 32'(qry_hit), 32'd0);

    // single issue, broadcast, commit two edges after the CDB
    issue(4'd5);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_iss_tag", 32'(iss_tag), 32'd1);
    chk("t1_empty", 32'(empty), 32'd0);
    cdb(3'd0, 16'h1234);
    chk("t1_no_bypass", 32'(cmt_valid), 32'd0);
    tick();
    chk("t1_cmt_valid", 32'(cmt_valid), 32'd1);
    chk("t1_cmt_dest", 32'(cmt_dest), 32'd5);
    chk("t1_cmt_tag", 32'(cmt_tag), 32'd0);
    chk("t1_cmt_value", 32'(cmt_value), 32'h1234);
    chk("t1_empty_after", 32'(empty), 32'd1);
    tick();
    chk("t1_pulse_one_cycle", 32'(cmt_valid), 32'd0);
    do_flush();
    chk("flush_iss_tag", 32'(iss_tag), 32'd0);

    // fill to 8, ignored 9th issue, then one commit frees a slot
    for (int i = 0; i < 8; i++) issue(4'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_iss_ready", 32'(iss_ready), 32'd0);
    chk("t2_count", 32'(count), 32'd8);
    chk("t2_iss_tag_wrap", 32'(iss_tag), 32'd0);
    issue(4'd15);
    chk("t2_9th_count", 32'(count), 32'd8);
    chk("t2_9th_tail", 32'(iss_tag), 32'd0);
    qry_reg = 4'd15;
    #1;
    chk("t2_9th_not_written", 32'(qry_hit), 32'd0);
    cdb(3'd0, 16'h00aa);
    chk("t2_no_cmt_yet", 32'(cmt_valid), 32'd0);
    tick();
    chk("t2_cmt_valid", 32'(cmt_valid), 32'd1);
    chk("t2_cmt_tag", 32'(cmt_tag), 32'd0);
    chk("t2_cmt_value", 32'(cmt_value), 32'h00aa);
    chk("t2_count7", 32'(count), 32'd7);
    chk("t2_iss_tag", 32'(iss_tag), 32'd0);
    chk("t2_not_full", 32'(full), 32'd0);
    do_flush();

    // out-of-order results still commit in order
    issue(4'd10);
    issue(4'd11);
    issue(4'd12);
    cdb(3'd2, 16'h0022);
    chk("t3_wait_a", 32'(cmt_valid), 32'd0);
    cdb(3'd1, 16'h0011);
    chk("t3_wait_b", 32'(cmt_valid), 32'd0);
    cdb(3'd0, 16'h0010);
    chk("t3_wait_c", 32'(cmt_valid), 32'd0);
    tick();
    chk("t3_c0_valid", 32'(cmt_valid), 32'd1);
    chk("t3_c0_tag", 32'(cmt_tag), 32'd0);
    chk("t3_c0_value", 32'(cmt_value), 32'h0010);
    tick();
    chk("t3_c1_valid", 32'(cmt_valid), 32'd1);
    chk("t3_c1_tag", 32'(cmt_tag), 32'd1);
    chk("t3_c1_dest", 32'(cmt_dest), 32'd11);
    tick();
    chk("t3_c2_valid", 32'(cmt_valid), 32'd1);
    chk("t3_c2_tag", 32'(cmt_tag), 32'd2);
    chk("t3_c2_value", 32'(cmt_value), 32'h0022);
    tick();
    chk("t3_done", 32'(cmt_valid), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    do_flush();

    // rename query picks the youngest writer
    issue(4'd3);
    issue(4'd3);
    qry_reg = 4'd3;
    #1;
    chk("t4_hit", 32'(qry_hit), 32'd1);
    chk("t4_tag", 32'(qry_tag), 32'd1);
    chk("t4_ready0", 32'(qry_ready), 32'd0);
    cdb(3'd1, 16'h0007);
    chk("t4_ready1", 32'(qry_ready), 32'd1);
    chk("t4_value", 32'(qry_value), 32'd7);
    chk("t4_tag_again", 32'(qry_tag), 32'd1);
    chk("t4_head_blocks", 32'(cmt_valid), 32'd0);
    qry_reg = 4'd9;
    #1;
    chk("t4_miss_hit", 32'(qry_hit), 32'd0);
    chk("t4_miss_tag", 32'(qry_tag), 32'd0);
    chk("t4_miss_value", 32'(qry_value), 32'd0);
    do_flush();

    // flush beats a pending commit, a CDB and an issue in the same cycle
    for (int i = 0; i < 4; i++) issue(4'(i + 4));
    cdb(3'd0, 16'h0abc);
    flush = 1'b1;
    iss_valid = 1'b1; iss_dest = 4'd8;
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 16'h0bbb;
    tick();
    flush = 1'b0; iss_valid = 1'b0; cdb_valid = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_cmt_valid", 32'(cmt_valid), 32'd0);
    chk("t5_iss_tag", 32'(iss_tag), 32'd0);
    qry_reg = 4'd4;
    #1;
    chk("t5_qry_cleared", 32'(qry_hit), 32'd0);
    tick();
    chk("t5_no_late_cmt", 32'(cmt_valid), 32'd0);

    // reset with a ready head: no commit, outputs back to reset values
    issue(4'd6);
    cdb(3'd0, 16'h5555);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    chk("t6_cmt_valid", 32'(cmt_valid), 32'd0);
    chk("t6_cmt_value", 32'(cmt_value), 32'd0);
    chk("t6_cmt_dest", 32'(cmt_dest), 32'd0);
    chk("t6_cmt_tag", 32'(cmt_tag), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_iss_ready", 32'(iss_ready), 32'd1);
    chk("t6_iss_tag", 32'(iss_tag), 32'd0);
    tick();
    chk("t6_no_cmt_after", 32'(cmt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, the width of result values.
REQ-002 SHALL provide parameter DEPTH, default 8, the number of ROB entries; fixed at 8 (3-bit tags).
REQ-003 SHALL have port clk1 input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n input 1, the reset: synchronous, active-low.
REQ-005 SHALL have port iss_valid input 1, the issue request.
REQ-006 SHALL have port iss_dest input 4, the architectural destination register (0-15).
REQ-007 SHALL have port iss_ready output 1, asserted when not full (combinational from state).
REQ-008 SHALL have port iss_tag output 3, the tag the next issue receives (= tail pointer).
REQ-009 SHALL have port cdb_valid input 1, the result broadcast valid.
REQ-010 SHALL have port cdb_tag input 3, the ROB tag of the result.
REQ-011 SHALL have port cdb_value input DATA_W, the result value.
REQ-012 SHALL have port cmt_valid output 1, the registered one-cycle commit pulse.
REQ-013 SHALL have port cmt_dest output 4, cmt_tag output 3 and cmt_value output DATA_W, the committed entry fields (registered).
REQ-014 SHALL have port flush input 1, the synchronous squash of all entries.
REQ-015 SHALL have port qry_reg input 4, the rename lookup register.
REQ-016 SHALL have port qry_hit output 1, qry_tag output 3, qry_ready output 1 and qry_value output DATA_W, the lookup result (combinational).
REQ-017 SHALL have ports count output 4, empty output 1 and full output 1, the occupancy.

Function
REQ-018 SHALL hold per entry: busy, ready, dest[3:0], value[DATA_W-1:0]; plus head_p[2:0], tail_p[2:0] and count[3:0].
REQ-019 SHALL drive empty = (count==0), full = (count==8) and iss_ready = ~full.
REQ-020 SHALL accept an issue when iss_valid & ~full: entry[tail_p] gets busy=1, ready=0, dest=iss_dest, and tail_p increments mod 8 (7 wraps to 0).
REQ-021 SHALL ignore iss_valid when full, leaving state unchanged; iss_ready is computed from pre-edge count, so a same-cycle commit does not unblock issue.
REQ-022 SHALL, when cdb_valid is high and entry[cdb_tag] is busy and not ready, set ready=1 and value=cdb_value.
REQ-023 SHALL ignore a broadcast to a non-busy or already-ready entry, including the entry being issued in the same cycle.
REQ-024 SHALL commit at most one entry per cycle, in order: if entry[head_p] is busy and ready on the pre-edge state, the next edge sets cmt_valid=1 with its dest/tag/value, clears its busy bit and increments head_p mod 8; otherwise cmt_valid=0.
REQ-025 SHALL give no CDB-to-commit bypass: a result broadcast at edge N sets ready, and cmt_valid goes high after edge N+1.
REQ-026 SHALL update count by +1 on an accepted issue and -1 on a commit; both in one cycle leave it unchanged.
REQ-027 SHALL, on flush=1, at the edge clear all busy/ready bits, set head_p=tail_p=0, count=0 and cmt_valid=0; flush overrides issue, CDB and commit in that cycle.
REQ-028 SHALL make qry_hit=1 when any busy entry has dest==qry_reg, and select the youngest match (largest (idx-head_p) mod 8); qry_tag, qry_ready and qry_value come from that entry.
REQ-029 SHALL drive qry_tag, qry_ready and qry_value to 0 when qry_hit=0; the query reflects pre-edge state only.

Reset
REQ-030 SHALL, while rst_n=0 at a clk1 edge, clear all entries, head_p, tail_p, count, cmt_valid, cmt_dest, cmt_tag and cmt_value to 0; then empty=1, full=0, iss_ready=1, iss_tag=0.
REQ-031 SHALL give reset priority over flush and all other inputs, and reset mid-operation discards all in-flight entries without emitting a commit.

Verification
REQ-032 SHALL cover: issue dest=5 (tag 0), CDB tag0 value=0x1234 -> cmt_valid one cycle, two edges after the CDB, with dest=5, tag=0, value=0x1234; empty=1 afterwards.
REQ-033 SHALL cover: issue 8 entries with no CDB -> full=1, iss_ready=0, a 9th issue is ignored and count stays 8; then CDB tag0 -> one commit, count=7, iss_tag=0 (wrapped).
REQ-034 SHALL cover: issue tags 0,1,2, CDB in order 2,1,0 -> commits occur in order 0,1,2 on consecutive cycles.
REQ-035 SHALL cover: issue dest=3 twice (tags 0,1), query qry_reg=3 -> qry_hit=1, qry_tag=1, qry_ready=0; after CDB tag1 value=7 -> qry_ready=1, qry_value=7; query reg 9 -> qry_hit=0.
REQ-036 SHALL cover: flush asserted with 4 busy entries and a simultaneous valid CDB/issue -> next cycle count=0, empty=1, cmt_valid=0, iss_tag=0.
REQ-037 SHALL cover: rst_n=0 for one edge mid-stream with head entry ready -> no commit pulse, all outputs at reset values.
